// File: rtl/usb_ulpi_top.sv
`default_nettype none
// ============================================================================
// Module      : usb_ulpi_top
// Description : ULPI link-side controller for a full-speed USB device.
//               Resets and configures the PHY (Function Control write), then
//               bridges ULPI receive traffic to an AXI-Stream OUT port and an
//               AXI-Stream IN port to ULPI transmit commands.
// Ports       : ulpi_clock_i  - 60 MHz PHY clock, sole clock of the block
//               areset_n      - synchronous active-low reset
//               reset_no      - PHY reset (active-low)
//               ulpi_dir_i / ulpi_nxt_i / ulpi_stp_o / ulpi_data_io - ULPI bus
//               usb_clock_o   - copy of ulpi_clock_i
//               usb_reset_o   - high until PHY initialisation completes
//               blk_error_i   - aborts the IN transmit in progress
//               blki_*        - AXI-Stream IN packet (first byte is the PID)
//               blko_*        - AXI-Stream OUT packet (PID included)
// Revision    : 1.0 - initial release
// ============================================================================
module usb_ulpi_top #(
  parameter int USE_EP2_IN  = 1,
  parameter int USE_EP1_OUT = 1
) (
  input  logic       ulpi_clock_i,
  input  logic       areset_n,
  output logic       reset_no,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o,
  inout  wire  [7:0] ulpi_data_io,
  output logic       usb_clock_o,
  output logic       usb_reset_o,
  input  logic       blk_error_i,
  input  logic       blki_tvalid_i,
  input  logic       blki_tlast_i,
  input  logic       blki_tkeep_i,
  input  logic [7:0] blki_tdata_i,
  output logic       blki_tready_o,
  output logic       blko_tvalid_o,
  output logic       blko_tlast_o,
  output logic       blko_tkeep_o,
  output logic [7:0] blko_tdata_o,
  input  logic       blko_tready_i
);

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_PHYRST   = 4'd1;
  localparam logic [3:0] S_WAIT     = 4'd2;
  localparam logic [3:0] S_REGW_CMD = 4'd3;
  localparam logic [3:0] S_REGW_DAT = 4'd4;
  localparam logic [3:0] S_REGW_STP = 4'd5;
  localparam logic [3:0] S_IDLE     = 4'd6;
  localparam logic [3:0] S_RX       = 4'd7;
  localparam logic [3:0] S_TX_CMD   = 4'd8;
  localparam logic [3:0] S_TX_DAT   = 4'd9;
  localparam logic [3:0] S_TX_STP   = 4'd10;
  localparam logic [3:0] S_ABORT    = 4'd11;

  localparam logic [7:0] REGW_FUNC_CTRL = 8'h84;  // register write, addr 0x04
  localparam logic [7:0] FUNC_CTRL_VAL  = 8'h45;  // FS xcvr, TermSelect, SuspendM
  localparam logic [7:0] ABORT_BYTE     = 8'hFF;

  logic clk;
  assign clk         = ulpi_clock_i;
  assign usb_clock_o = ulpi_clock_i;

  logic ep1_en;
  logic ep2_en;

  generate
    if (USE_EP1_OUT != 0) begin : g_ep1_out_on
      assign ep1_en = 1'b1;
    end else begin : g_ep1_out_off
      assign ep1_en = 1'b0;
    end
    if (USE_EP2_IN != 0) begin : g_ep2_in_on
      assign ep2_en = 1'b1;
    end else begin : g_ep2_in_off
      assign ep2_en = 1'b0;
    end
  endgenerate

  logic       unused_tkeep;
  assign unused_tkeep = blki_tkeep_i;

  // --------------------------------------------------------------------------
  // State and bookkeeping registers
  // --------------------------------------------------------------------------
  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] rst_cnt;
  logic       dir_q;
  logic       usb_rst_q;

  logic [7:0] data_out;
  logic       stp;
  logic       tready;
  logic       drive_en;

  always_comb begin
    state_nxt = state;
    data_out  = 8'h00;
    stp       = 1'b0;
    tready    = 1'b0;
    case (state)
      S_RESET: begin
        stp       = 1'b1;
        state_nxt = S_PHYRST;
      end
      S_PHYRST: begin
        if (rst_cnt == 4'hF) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!ulpi_dir_i && !dir_q) state_nxt = S_REGW_CMD;
      end
      S_REGW_CMD: begin
        data_out = REGW_FUNC_CTRL;
        if (ulpi_dir_i)      state_nxt = S_WAIT;
        else if (ulpi_nxt_i) state_nxt = S_REGW_DAT;
      end
      S_REGW_DAT: begin
        data_out = FUNC_CTRL_VAL;
        if (ulpi_dir_i)      state_nxt = S_WAIT;
        else if (ulpi_nxt_i) state_nxt = S_REGW_STP;
      end
      S_REGW_STP: begin
        stp       = 1'b1;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (ulpi_dir_i)                   state_nxt = S_RX;
        else if (blki_tvalid_i && ep2_en) state_nxt = S_TX_CMD;
      end
      S_RX: begin
        if (!ulpi_dir_i) state_nxt = S_IDLE;
      end
      S_TX_CMD: begin
        data_out = {4'h4, blki_tdata_i[3:0]};
        if (ulpi_dir_i) begin
          state_nxt = S_ABORT;
        end else if (ulpi_nxt_i) begin
          tready    = 1'b1;
          state_nxt = blki_tlast_i ? S_TX_STP : S_TX_DAT;
        end
      end
      S_TX_DAT: begin
        data_out = blki_tdata_i;
        if (ulpi_dir_i) begin
          state_nxt = S_ABORT;
        end else if (blk_error_i) begin
          // The bus carries 0xFF this cycle, not the stream byte, so the
          // stream byte is left for the ABORT drain.
          stp       = 1'b1;
          data_out  = ABORT_BYTE;
          state_nxt = S_ABORT;
        end else begin
          tready = ulpi_nxt_i;
          if (ulpi_nxt_i && blki_tvalid_i && blki_tlast_i) state_nxt = S_TX_STP;
        end
      end
      S_TX_STP: begin
        stp       = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ABORT: begin
        tready = 1'b1;
        if (blki_tvalid_i && blki_tlast_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // Link drives only when dir has been low this cycle and the previous one,
  // which keeps the turnaround cycles undriven.
  assign drive_en = !ulpi_dir_i && !dir_q &&
                    (state != S_RESET) && (state != S_PHYRST) && (state != S_WAIT);
  assign ulpi_data_io  = drive_en ? data_out : 8'hzz;
  assign ulpi_stp_o    = stp;
  assign blki_tready_o = tready && ep2_en;
  assign reset_no      = (state != S_RESET) && (state != S_PHYRST);
  assign usb_reset_o   = usb_rst_q;

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state     <= S_RESET;
      rst_cnt   <= 4'd0;
      dir_q     <= 1'b0;
      usb_rst_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      dir_q   <= ulpi_dir_i;
      rst_cnt <= (state == S_PHYRST) ? rst_cnt + 4'd1 : 4'd0;
      if (state == S_REGW_STP) usb_rst_q <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Receive path: one-byte hold register feeding a one-beat output register.
  // The hold register lets the final byte be tagged tlast once the end of
  // packet is seen.
  // --------------------------------------------------------------------------
  logic       hold_valid;
  logic [7:0] hold_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_keep;
  logic       pkt_bad;
  logic       rx_err;
  logic       eop_pend;

  logic       rx_active;
  logic       rx_cmd_cyc;
  logic       rx_dat_cyc;
  logic       dir_fall;
  logic [1:0] rx_evt;
  logic       eop_evt;
  logic       err_evt;
  logic       out_free;

  assign rx_active  = ulpi_dir_i && dir_q && !usb_rst_q;
  assign rx_cmd_cyc = rx_active && !ulpi_nxt_i;
  assign rx_dat_cyc = rx_active && ulpi_nxt_i && ep1_en;
  assign dir_fall   = dir_q && !ulpi_dir_i && !usb_rst_q;
  assign rx_evt     = ulpi_data_io[5:4];
  assign eop_evt    = (rx_cmd_cyc && (rx_evt == 2'b00)) || dir_fall;
  assign err_evt    = rx_cmd_cyc && (rx_evt == 2'b11);
  assign out_free   = !out_valid || blko_tready_i;

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      out_keep   <= 1'b0;
      pkt_bad    <= 1'b0;
      rx_err     <= 1'b0;
      eop_pend   <= 1'b0;
    end else begin
      if (out_valid && blko_tready_i) out_valid <= 1'b0;
      if (err_evt) rx_err <= 1'b1;

      if (rx_dat_cyc && !eop_pend) begin
        if (!hold_valid) begin
          hold_valid <= 1'b1;
          hold_data  <= ulpi_data_io;
        end else if (out_free) begin
          out_valid <= 1'b1;
          out_data  <= hold_data;
          out_last  <= 1'b0;
          out_keep  <= 1'b1;
          hold_data <= ulpi_data_io;
        end else begin
          pkt_bad <= 1'b1;  // output still occupied: byte lost
        end
      end else if (hold_valid && (eop_evt || eop_pend)) begin
        // End seen: flush the held byte as the last beat, waiting for the
        // output register if the sink is still holding the previous beat.
        if (out_free) begin
          out_valid  <= 1'b1;
          out_data   <= hold_data;
          out_last   <= 1'b1;
          out_keep   <= !(pkt_bad || rx_err || err_evt);
          hold_valid <= 1'b0;
          pkt_bad    <= 1'b0;
          rx_err     <= 1'b0;
          eop_pend   <= 1'b0;
        end else begin
          eop_pend <= 1'b1;
        end
      end else if (eop_evt) begin
        pkt_bad <= 1'b0;  // packet without data bytes: nothing to emit
        rx_err  <= 1'b0;
      end
    end
  end

  assign blko_tvalid_o = out_valid && ep1_en;
  assign blko_tdata_o  = out_data;
  assign blko_tlast_o  = out_last;
  assign blko_tkeep_o  = out_keep;

endmodule
`default_nettype wire

// File: tb/tb_usb_ulpi_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_ulpi_top
// Description : Self-checking bench for usb_ulpi_top: PHY init, table-driven
//               receive vectors, and hand-written transmit/abort/reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_ulpi_top;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       areset_n;
  logic       reset_no;
  logic       dir;
  logic       nxt;
  logic       stp;
  wire  [7:0] ulpi_data;
  logic [7:0] phy_data;
  logic       usb_clock;
  logic       usb_reset;
  logic       blk_error;
  logic       blki_tvalid;
  logic       blki_tlast;
  logic [7:0] blki_tdata;
  logic       blki_tready;
  logic       blko_tvalid;
  logic       blko_tlast;
  logic       blko_tkeep;
  logic [7:0] blko_tdata;
  logic       blko_tready;

  assign ulpi_data = dir ? phy_data : 8'hzz;

  usb_ulpi_top #(.USE_EP2_IN(1), .USE_EP1_OUT(1)) dut (
    .ulpi_clock_i (clk),
    .areset_n     (areset_n),
    .reset_no     (reset_no),
    .ulpi_dir_i   (dir),
    .ulpi_nxt_i   (nxt),
    .ulpi_stp_o   (stp),
    .ulpi_data_io (ulpi_data),
    .usb_clock_o  (usb_clock),
    .usb_reset_o  (usb_reset),
    .blk_error_i  (blk_error),
    .blki_tvalid_i(blki_tvalid),
    .blki_tlast_i (blki_tlast),
    .blki_tkeep_i (1'b1),
    .blki_tdata_i (blki_tdata),
    .blki_tready_o(blki_tready),
    .blko_tvalid_o(blko_tvalid),
    .blko_tlast_o (blko_tlast),
    .blko_tkeep_o (blko_tkeep),
    .blko_tdata_o (blko_tdata),
    .blko_tready_i(blko_tready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // IN stream source: src[src_idx] is offered until accepted.
  logic [7:0] src [0:7];
  int         src_len = 0;
  int         src_idx = 0;

  task automatic src_drive();
    blki_tvalid = (src_idx < src_len);
    blki_tdata  = (src_idx < src_len) ? src[src_idx] : 8'h00;
    blki_tlast  = (src_idx == src_len - 1);
  endtask

  task automatic tick();
    logic acc;
    #1;
    acc = blki_tvalid && blki_tready;
    @(posedge clk);
    #1;
    if (acc) src_idx++;
    src_drive();
    #1;
  endtask

  task automatic do_init(input string tag);
    int low;
    low = 0;
    tick();  // first released cycle enters PHYRST
    for (int i = 0; i < 40 && reset_no == 1'b0; i++) begin
      low++;
      tick();
    end
    chk({tag, "_phyrst_len"}, low, 16);
    tick();
    chk({tag, "_regw_cmd"}, ulpi_data, 8'h84);
    tick();
    chk({tag, "_regw_dat"}, ulpi_data, 8'h45);
    tick();
    chk({tag, "_regw_stp"}, stp, 1);
    chk({tag, "_regw_stp_bus"}, ulpi_data, 8'h00);
    chk({tag, "_usbrst_before"}, usb_reset, 1);
    tick();
    chk({tag, "_usbrst_after"}, usb_reset, 0);
    chk({tag, "_idle_stp"}, stp, 0);
    chk({tag, "_idle_bus"}, ulpi_data, 8'h00);
  endtask

  typedef struct {
    logic       dir;
    logic       nxt;
    logic [7:0] dat;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       ek;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic d, input logic n, input logic [7:0] b,
                              input logic r, input logic ev, input logic [7:0] ed,
                              input logic el, input logic ek);
    vec_t v;
    v.dir = d; v.nxt = n; v.dat = b; v.rdy = r;
    v.ev = ev; v.ed = ed; v.el = el; v.ek = ek;
    return v;
  endfunction

  initial begin
    areset_n    = 1'b0;
    dir         = 1'b0;
    nxt         = 1'b1;
    phy_data    = 8'h00;
    blk_error   = 1'b0;
    blko_tready = 1'b1;
    src_drive();

    // Expected beat after each cycle: {dir,nxt,data,rdy, valid,data,last,keep}
    // Clean packet ended by RX CMD 0x00.
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 8'hC3, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 8'h01, 1, 1, 8'hC3, 0, 1));
    vt.push_back(mk(1, 1, 8'h02, 1, 1, 8'h01, 0, 1));
    vt.push_back(mk(1, 0, 8'h00, 1, 1, 8'h02, 1, 1));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    // Error RxEvent before end -> last beat tkeep=0.
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 8'hC3, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 8'h01, 1, 1, 8'hC3, 0, 1));
    vt.push_back(mk(1, 1, 8'h02, 1, 1, 8'h01, 0, 1));
    vt.push_back(mk(1, 0, 8'h30, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 1, 8'h02, 1, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    // Packet ended by dir falling, then an empty packet.
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 8'hA7, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 1, 8'hA7, 1, 1));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
    // Backpressure: 0x02 dropped, end deferred until sink frees up.
    vt.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h10, 0, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 8'hC3, 0, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 8'h01, 0, 1, 8'hC3, 0, 1));
    vt.push_back(mk(1, 1, 8'h02, 0, 1, 8'hC3, 0, 1));
    vt.push_back(mk(1, 0, 8'h00, 0, 1, 8'hC3, 0, 1));
    vt.push_back(mk(0, 0, 8'h00, 1, 1, 8'h01, 1, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0));

    // Reset state
    tick(); tick(); tick();
    chk("rst_reset_no", reset_no, 0);
    chk("rst_usb_reset", usb_reset, 1);
    chk("rst_stp", stp, 1);
    chk("rst_tready", blki_tready, 0);
    chk("rst_tvalid_out", blko_tvalid, 0);
    chk("usb_clock", usb_clock, clk);

    areset_n = 1'b1;
    do_init("init");

    // Receive vectors
    for (int i = 0; i < vt.size(); i++) begin
      dir         = vt[i].dir;
      nxt         = vt[i].nxt;
      phy_data    = vt[i].dat;
      blko_tready = vt[i].rdy;
      tick();
      chk($sformatf("rx%0d_valid", i), blko_tvalid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("rx%0d_data", i), blko_tdata, vt[i].ed);
        chk($sformatf("rx%0d_last", i), blko_tlast, vt[i].el);
        chk($sformatf("rx%0d_keep", i), blko_tkeep, vt[i].ek);
      end
    end
    dir = 1'b0; nxt = 1'b0; blko_tready = 1'b1;
    tick();

    // Normal IN transmit
    src[0] = 8'hC3; src[1] = 8'hAA; src[2] = 8'h55;
    src_len = 3; src_idx = 0; src_drive(); #1;
    chk("tx_idle_bus", ulpi_data, 8'h00);
    chk("tx_idle_stp", stp, 0);
    chk("tx_idle_tready", blki_tready, 0);
    tick();
    chk("tx_cmd_bus", ulpi_data, 8'h43);
    chk("tx_cmd_tready_nonxt", blki_tready, 0);
    nxt = 1'b1; #1;
    chk("tx_cmd_tready", blki_tready, 1);
    tick();
    chk("tx_dat0_bus", ulpi_data, 8'hAA);
    chk("tx_dat0_tready", blki_tready, 1);
    tick();
    chk("tx_dat1_bus", ulpi_data, 8'h55);
    tick();
    chk("tx_stp", stp, 1);
    chk("tx_stp_bus", ulpi_data, 8'h00);
    tick();
    chk("tx_end_stp", stp, 0);
    chk("tx_consumed", src_idx, 3);

    // blk_error abort after the first data byte
    src[0] = 8'hC3; src[1] = 8'hAA; src[2] = 8'h55; src[3] = 8'h66;
    src_len = 4; src_idx = 0; src_drive(); #1;
    tick();
    chk("err_cmd_bus", ulpi_data, 8'h43);
    tick();
    chk("err_dat_bus", ulpi_data, 8'hAA);
    tick();
    blk_error = 1'b1; nxt = 1'b0; #1;
    chk("err_stp", stp, 1);
    chk("err_bus", ulpi_data, 8'hFF);
    tick();
    blk_error = 1'b0; nxt = 1'b1; #1;
    chk("err_abort_tready", blki_tready, 1);
    chk("err_abort_stp", stp, 0);
    tick();
    tick();
    chk("err_drained", src_idx, 4);
    chk("err_idle_stp", stp, 0);
    chk("err_idle_bus", ulpi_data, 8'h00);
    chk("err_idle_tready", blki_tready, 0);

    // dir rises during TX_DAT
    src[0] = 8'hC3; src[1] = 8'h11; src[2] = 8'h22; src[3] = 8'h33;
    src_len = 4; src_idx = 0; src_drive(); #1;
    tick();
    tick();
    chk("dirab_dat_bus", ulpi_data, 8'h11);
    tick();
    dir = 1'b1; nxt = 1'b0; phy_data = 8'h00; #1;
    chk("dirab_no_stp", stp, 0);
    chk("dirab_tready", blki_tready, 0);
    tick();
    phy_data = 8'h10; #1;
    chk("dirab_abort_tready", blki_tready, 1);
    chk("dirab_abort_stp", stp, 0);
    tick();
    phy_data = 8'h5A; nxt = 1'b1;
    tick();
    phy_data = 8'h00; nxt = 1'b0;
    tick();
    chk("dirab_drained", src_idx, 4);
    chk("dirab_rx_valid", blko_tvalid, 1);
    chk("dirab_rx_data", blko_tdata, 8'h5A);
    chk("dirab_rx_last", blko_tlast, 1);
    chk("dirab_rx_keep", blko_tkeep, 1);
    dir = 1'b0;
    tick();
    chk("dirab_rx_done", blko_tvalid, 0);
    tick();
    chk("dirab_idle_stp", stp, 0);
    chk("dirab_idle_bus", ulpi_data, 8'h00);

    // Reset mid-packet: held byte must be discarded
    dir = 1'b1; nxt = 1'b0; phy_data = 8'h00;
    tick();
    phy_data = 8'h10;
    tick();
    phy_data = 8'hC3; nxt = 1'b1;
    tick();
    src[0] = 8'h77; src_len = 1; src_idx = 0; src_drive();
    areset_n = 1'b0; dir = 1'b0; nxt = 1'b1;
    tick();
    chk("mid_rst_reset_no", reset_no, 0);
    chk("mid_rst_usb_reset", usb_reset, 1);
    chk("mid_rst_stp", stp, 1);
    chk("mid_rst_tready", blki_tready, 0);
    chk("mid_rst_tvalid_out", blko_tvalid, 0);
    src_len = 0; src_idx = 0; src_drive();
    tick();
    areset_n = 1'b1;
    do_init("reinit");
    dir = 1'b1; nxt = 1'b0; phy_data = 8'h00;
    tick();
    dir = 1'b0;
    tick();
    chk("mid_rst_no_stale_beat", blko_tvalid, 0);
    tick();
    chk("mid_rst_no_stale_beat2", blko_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_ulpi_top.md
USB_ULPI_TOP -- requirements
Module: usb_ulpi_top

Interface
REQ-001 SHALL have parameter USE_EP2_IN, default 1: 1 enables the BULK IN transmit path; 0 forces blki_tready_o=0 and no transmits.
REQ-002 SHALL have parameter USE_EP1_OUT, default 1: 1 enables the BULK OUT receive path; 0 forces blko_tvalid_o=0 and discards received bytes.
REQ-003 SHALL use a single clock and a synchronous, active-low reset.
REQ-004 ulpi_clock_i  in  1  60 MHz PHY clock; sole clock of the block.
REQ-005 areset_n  in  1  reset, synchronous to ulpi_clock_i, active-low.
REQ-006 reset_no  out  1  PHY reset, active-low.
REQ-007 ulpi_dir_i  in  1  ULPI bus direction: 1 means PHY drives data.
REQ-008 ulpi_nxt_i  in  1  ULPI next/throttle.
REQ-009 ulpi_stp_o  out  1  ULPI stop.
REQ-010 ulpi_data_io  inout  8  ULPI data; link drives it only when dir=0 (previous and current cycle), else hi-Z.
REQ-011 usb_clock_o  out  1  equals ulpi_clock_i.
REQ-012 usb_reset_o  out  1  active-high; high until PHY initialisation completes.
REQ-013 blk_error_i  in  1  aborts the current IN transmit.
REQ-014 blki_tvalid_i/tlast_i/tkeep_i in 1 each; blki_tdata_i in 8; blki_tready_o out 1: AXI-Stream IN packet, first byte is the PID.
REQ-015 blko_tvalid_o/tlast_o/tkeep_o out 1 each; blko_tdata_o out 8; blko_tready_i in 1: AXI-Stream OUT packet of received bytes, PID included.

Function
REQ-016 States SHALL be: RESET, PHYRST, WAIT, REGW_CMD, REGW_DAT, REGW_STP, IDLE, RX, TX_CMD, TX_DAT, TX_STP, ABORT.
REQ-017 PHYRST: reset_no=0 for 16 cycles, then go to WAIT.
REQ-018 WAIT: when dir=0 for 2 consecutive cycles, go to REGW_CMD.
REQ-019 REGW_CMD: drive 0x84 (write Function Control); on nxt=1 go to REGW_DAT.
REQ-020 REGW_DAT: drive 0x45 (FS transceiver, TermSelect=1, SuspendM=1); on nxt=1 go to REGW_STP.
REQ-021 REGW_STP: drive stp=1 with data 0x00 for 1 cycle; usb_reset_o falls on the next cycle; then go to IDLE.
REQ-022 dir=1 during REGW_CMD or REGW_DAT SHALL abort the write and return to WAIT to retry.
REQ-023 A cycle in which dir differs from the previous cycle SHALL be a turnaround: data ignored, not driven.
REQ-024 With dir=1 and no turnaround: nxt=0 means the data byte is an RX CMD; nxt=1 means a received data byte.
REQ-025 The latest RX CMD SHALL be stored; RxEvent=bits[5:4]: 01 active, 11 error, 00 inactive.
REQ-026 Receive SHALL use a one-byte hold register: each new byte releases the held byte as a beat with tlast=0, tkeep=1.
REQ-027 End of packet (RxEvent 00, or dir falls) SHALL emit the held byte with tlast=1; tkeep=1 if clean, tkeep=0 if RxEvent=11 occurred or any byte was dropped.
REQ-028 A beat SHALL stay valid until blko_tready_i; a byte arriving while the output is occupied SHALL be dropped and marks the packet bad.
REQ-029 A packet with no data bytes SHALL emit nothing.
REQ-030 TX SHALL start only from IDLE with dir=0 and blki_tvalid_i=1.
REQ-031 TX_CMD: drive 0x40|blki_tdata_i[3:0]; on nxt=1 consume the PID byte (tready=1 that cycle); go to TX_DAT, or TX_STP if tlast.
REQ-032 TX_DAT: drive blki_tdata_i; blki_tready_o = nxt & ~dir; after the tlast byte is accepted go to TX_STP.
REQ-033 TX_STP: stp=1, data 0x00 for 1 cycle, then IDLE.
REQ-034 blk_error_i=1 in TX_DAT SHALL drive stp=1 with data 0xFF for 1 cycle, then go to ABORT.
REQ-035 dir rising in TX_CMD or TX_DAT SHALL go to ABORT without stp.
REQ-036 ABORT: blki_tready_o=1 until the tlast beat is consumed, then IDLE.
REQ-037 In IDLE with dir=0, the link SHALL drive 0x00 with stp=0.

Reset
REQ-038 areset_n=0 SHALL give: state RESET, reset_no=0, usb_reset_o=1, ulpi_stp_o=1, blki_tready_o=0, blko_tvalid_o=0, hold register empty; bus hi-Z.
REQ-039 The first cycle with areset_n=1 SHALL enter PHYRST.
REQ-040 Reset asserted mid-packet SHALL discard all packet state.

Verification
REQ-041 Release reset with dir=0 and nxt asserted when requested -> reset_no low for 16 cycles; bus shows 0x84, 0x45, then stp with 0x00; usb_reset_o=0 afterwards.
REQ-042 PHY sends RX CMD 0x10, data 0xC3 0x01 0x02, RX CMD 0x00 -> blko beats C3, 01, 02; tlast on 02; tkeep=1.
REQ-043 Same packet but RX CMD 0x30 before end -> final beat tlast=1, tkeep=0.
REQ-044 blki sends 0xC3, 0xAA, 0x55 (tlast), nxt=1 -> bus shows 0x43, AA, 55, then stp with 0x00.
REQ-045 blk_error_i=1 after the first data byte -> stp with 0xFF; the rest of the packet is drained; state returns to IDLE.
REQ-046 dir rises during TX_DAT -> no stp; remaining IN bytes are drained; the RX path then receives normally.
